// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with IDLE/RUN/DONE sequencing
// Signed-overflow output ovf is built only when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry_next;

    assign w_accept     = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last       = (r_cnt == LAST);
    assign w_sum_bit    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    // Operands shift right so bit 0 is always the current column; sum bits enter at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
            r_carry <= w_carry_next;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign s = r_sum;
    assign c = r_carry;

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the MSB column r_carry is the carry in, w_carry_next the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_ovf <= r_carry ^ w_carry_next;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit, single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit, request to begin an addition.
REQ-005 SHALL have port a, input, WIDTH bits, operand A, unsigned.
REQ-006 SHALL have port b, input, WIDTH bits, operand B, unsigned.
REQ-007 SHALL have port cin, input, 1 bit, carry-in.
REQ-008 SHALL have port s, output, WIDTH bits, sum.
REQ-009 SHALL have port c, output, 1 bit, carry-out.
REQ-010 SHALL have port busy, output, 1 bit, high while an addition is in progress.
REQ-011 SHALL have port done, output, 1 bit, one-cycle pulse when s and c are valid.
REQ-012 SHALL have port ovf, output, 1 bit, signed overflow; present only under SERIAL_ADDER_OVF_EN.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE or DONE with start=1 at a rising edge, latch a, b, cin, clear the bit counter, and enter RUN.
REQ-015 SHALL, in RUN, compute one sum bit per cycle, LSB first, using full-adder logic (sum = x^y^carry; carry = majority), storing the carry in a register between bits.
REQ-016 SHALL remain in RUN for exactly WIDTH cycles, then enter DONE.
REQ-017 SHALL remain in DONE for one cycle, then enter IDLE unless start=1 (see REQ-014).
REQ-018 SHALL drive busy=1 exactly when the state is RUN.
REQ-019 SHALL drive done=1 exactly when the state is DONE.
REQ-020 SHALL meet this latency: start sampled at edge k gives busy high for cycles k+1..k+WIDTH, and done high in cycle k+WIDTH+1.
REQ-021 SHALL ignore start while in RUN, with no effect on the latched operands or the result.
REQ-022 SHALL hold s and c stable from the DONE cycle until the next accepted start.
REQ-023 SHALL leave s and c undefined for use while busy=1 (intermediate shift contents).
REQ-024 SHALL produce {c,s} = a + b + cin modulo 2^(WIDTH+1).
REQ-025 SHALL ignore changes on a, b and cin after the accepting edge.

Reset
REQ-026 SHALL, on rst_n low, immediately force the state to IDLE, and s, c, busy, done, ovf, the carry register and the counter to 0, regardless of clock.
REQ-027 SHALL abandon an in-progress addition when reset asserts mid-RUN, with no done pulse for it.
REQ-028 SHALL accept start at the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro SERIAL_ADDER_OVF_EN defined, include port ovf, set in the DONE cycle to (carry into MSB) XOR (carry out of MSB), and hold it with s and c.
REQ-030 SHALL, without SERIAL_ADDER_OVF_EN, omit port ovf and its logic, with all other behaviour identical.

Verification (WIDTH=8)
REQ-031 SHALL cover: a=0x00, b=0x00, cin=0, start pulse -> done 9 cycles after the accepting edge, s=0x00, c=0, busy high 8 cycles.
REQ-032 SHALL cover: a=0xFF, b=0x01, cin=0 -> s=0x00, c=1; and a=0xA5, b=0x5A, cin=1 -> s=0x00, c=1.
REQ-033 SHALL cover (macro defined): a=0x7F, b=0x01, cin=0 -> s=0x80, c=0, ovf=1; a=0xFF, b=0x01 -> ovf=0.
REQ-034 SHALL cover: start re-pulsed with new operands during RUN -> ignored; result equals the first operands; exactly one done pulse.
REQ-035 SHALL cover: rst_n low at the 4th RUN cycle -> all outputs 0 at once, no done; a fresh start after release -> correct result.
REQ-036 SHALL cover: start held high in the DONE cycle with a=0x10, b=0x20 -> a new run begins with no idle cycle; the next done gives s=0x30, c=0.
